// File: rtl/dbg_monitor_pkg.sv
// dbg_monitor_pkg: shared types and constants for the GAT pipeline debug monitor.
//   dbg_state_e    capture FSM state encoding
//   ST_*           the same encodings as plain constants for the FSM registers
//   SEL_*          readout select map used by dbg_monitor's rd_sel_i
package dbg_monitor_pkg;

   typedef enum logic [1:0] {
      DBG_IDLE    = 2'd0,
      DBG_ARMED   = 2'd1,
      DBG_CAPTURE = 2'd2,
      DBG_DONE    = 2'd3
   } dbg_state_e;

   localparam logic [1:0] ST_IDLE    = 2'd0;
   localparam logic [1:0] ST_ARMED   = 2'd1;
   localparam logic [1:0] ST_CAPTURE = 2'd2;
   localparam logic [1:0] ST_DONE    = 2'd3;

   localparam logic [7:0] SEL_ID       = 8'd0;
   localparam logic [7:0] SEL_STICKY   = 8'd1;
   localparam logic [7:0] SEL_STATUS   = 8'd2;
   localparam logic [7:0] SEL_TS       = 8'd3;
   localparam logic [7:0] SEL_CNT_BASE = 8'd16;
   localparam logic [7:0] SEL_BUF_BASE = 8'd32;
   localparam logic [7:0] SEL_TS_BASE  = 8'd48;

endpackage

// File: rtl/dbg_monitor_if.sv
// dbg_monitor_if: observed pipeline signals fed into the debug monitor.
//   vld_i / rdy_i   per-channel valid/ready pairs (NUM_CH wide)
//   cap_en_i        capture-bus strobe
//   cap_addr_i      capture-bus address (ADDR_W)
//   cap_data_i      capture-bus data (CAP_W)
// master: the pipeline side driving the signals; slave: the monitor.
interface dbg_monitor_if #(
   parameter int NUM_CH = 8,
   parameter int ADDR_W = 16,
   parameter int CAP_W  = 32
);
   logic [NUM_CH-1:0] vld_i;
   logic [NUM_CH-1:0] rdy_i;
   logic              cap_en_i;
   logic [ADDR_W-1:0] cap_addr_i;
   logic [CAP_W-1:0]  cap_data_i;

   modport master (
      output vld_i, rdy_i, cap_en_i, cap_addr_i, cap_data_i
   );

   modport slave (
      input vld_i, rdy_i, cap_en_i, cap_addr_i, cap_data_i
   );
endinterface

// File: rtl/dbg_monitor_sat_counter.sv
// dbg_sat_counter: W-bit up-counter that sticks at all-ones instead of wrapping.
//   clk, rst_n   clock, async active-low reset
//   clr_i        synchronous clear, dominates inc_i
//   inc_i        count enable
//   cnt_o        current count
module dbg_sat_counter #(
   parameter int W = 32
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic         clr_i,
   input  logic         inc_i,
   output logic [W-1:0] cnt_o
);

   logic [W-1:0] cnt_q;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt_q <= '0;
      end else if (clr_i) begin
         cnt_q <= '0;
      end else if (inc_i && !(&cnt_q)) begin
         cnt_q <= cnt_q + W'(1);
      end
   end

   assign cnt_o = cnt_q;

endmodule

// File: rtl/dbg_monitor.sv
// dbg_monitor: on-chip debug monitor for the GAT pipeline.
// Records sticky valid/ready activity, saturating per-channel handshake counts,
// and a window of capture-bus words following an address-match trigger.
// Everything is read back through one registered 32-bit select port.
//
// Ports:
//   clk, rst_n    clock, async active-low reset
//   clr_i         sync clear of sticky flags, counters, capture FSM (buffer kept)
//   mon           dbg_monitor_if.slave: vld_i/rdy_i, cap_en_i/cap_addr_i/cap_data_i
//   arm_i         arm the trigger (honoured in IDLE only)
//   trig_addr_i   trigger match address
//   rd_sel_i      readout select
//   rd_data_o     readout data, one cycle after rd_sel_i
//   sticky_o      {rdy_sticky, vld_sticky}
//   state_o       capture FSM state
//
// Build option: define DBG_MONITOR_TIMESTAMP_EN to add a free-running cycle
// counter and a per-entry timestamp buffer (selects 3 and 48+i).
//
// state   | meaning
// --------+--------------------------------------------------------
// IDLE    | not armed, waiting for arm_i
// ARMED   | waiting for cap_en_i with cap_addr_i == trig_addr_i
// CAPTURE | storing every cap_en_i word until CAP_DEPTH entries held
// DONE    | buffer full, holds until clr_i
module dbg_monitor
   import dbg_monitor_pkg::*;
#(
   parameter int          NUM_CH    = 8,
   parameter int          CNT_W     = 32,
   parameter int          CAP_W     = 32,
   parameter int          CAP_DEPTH = 4,
   parameter int          ADDR_W    = 16,
   parameter logic [31:0] DBG_ID    = 32'h0022_2103
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  clr_i,
   dbg_monitor_if.slave          mon,
   input  logic                  arm_i,
   input  logic [ADDR_W-1:0]     trig_addr_i,
   input  logic [7:0]            rd_sel_i,
   output logic [31:0]           rd_data_o,
   output logic [2*NUM_CH-1:0]   sticky_o,
   output logic [1:0]            state_o
);

   localparam int IDX_W = $clog2(CAP_DEPTH);

   // ---------------- sticky flags ----------------
   logic [NUM_CH-1:0] vld_stk_q, rdy_stk_q;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         vld_stk_q <= '0;
         rdy_stk_q <= '0;
      end else if (clr_i) begin
         vld_stk_q <= '0;
         rdy_stk_q <= '0;
      end else begin
         vld_stk_q <= vld_stk_q | mon.vld_i;
         rdy_stk_q <= rdy_stk_q | mon.rdy_i;
      end
   end

   assign sticky_o = {rdy_stk_q, vld_stk_q};

   // ---------------- handshake counters ----------------
   logic [CNT_W-1:0] cnt [NUM_CH];

   for (genvar g = 0; g < NUM_CH; g++) begin : g_cnt
      dbg_sat_counter #(.W(CNT_W)) u_cnt (
         .clk   (clk),
         .rst_n (rst_n),
         .clr_i (clr_i),
         .inc_i (mon.vld_i[g] & mon.rdy_i[g]),
         .cnt_o (cnt[g])
      );
   end

   // ---------------- capture FSM ----------------
   logic [1:0] state_q, state_d;
   logic [4:0] cap_cnt_q, cap_cnt_d;
   logic       wr_en;
   logic [IDX_W-1:0] wr_idx;

   // In ARMED cap_cnt_q is 0, so one index expression serves both write states.
   assign wr_idx = cap_cnt_q[IDX_W-1:0];

   always_comb begin
      state_d   = state_q;
      cap_cnt_d = cap_cnt_q;
      wr_en     = 1'b0;
      case (state_q)
         ST_IDLE: begin
            if (arm_i) state_d = ST_ARMED;
         end
         ST_ARMED: begin
            if (mon.cap_en_i && (mon.cap_addr_i == trig_addr_i)) begin
               wr_en     = 1'b1;
               cap_cnt_d = 5'd1;
               state_d   = ST_CAPTURE;
            end
         end
         ST_CAPTURE: begin
            if (mon.cap_en_i) begin
               wr_en     = 1'b1;
               cap_cnt_d = cap_cnt_q + 5'd1;
               if (cap_cnt_q == 5'(CAP_DEPTH - 1)) state_d = ST_DONE;
            end
         end
         default: ;
      endcase
      if (clr_i) begin
         state_d   = ST_IDLE;
         cap_cnt_d = '0;
         wr_en     = 1'b0;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q   <= ST_IDLE;
         cap_cnt_q <= '0;
      end else begin
         state_q   <= state_d;
         cap_cnt_q <= cap_cnt_d;
      end
   end

   assign state_o = state_q;

   // Buffer is zeroed only by reset; clr_i leaves the last window readable.
   logic [CAP_W-1:0] cap_buf_q [CAP_DEPTH];

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < CAP_DEPTH; i++) cap_buf_q[i] <= '0;
      end else if (wr_en) begin
         cap_buf_q[wr_idx] <= mon.cap_data_i;
      end
   end

   // ---------------- readout ----------------
   // Tables padded to 16 entries so the select's low nibble indexes them
   // directly; padding entries read as 0.
   logic [31:0] cnt_ext [16];
   logic [31:0] buf_ext [16];
   logic [31:0] ts_ext  [16];
   logic [31:0] ts_cur;

   for (genvar g = 0; g < 16; g++) begin : g_ext
      if (g < NUM_CH) begin : g_cnt_on
         assign cnt_ext[g] = 32'(cnt[g]);
      end else begin : g_cnt_off
         assign cnt_ext[g] = '0;
      end
      if (g < CAP_DEPTH) begin : g_buf_on
         assign buf_ext[g] = 32'(cap_buf_q[g]);
      end else begin : g_buf_off
         assign buf_ext[g] = '0;
      end
   end

`ifdef DBG_MONITOR_TIMESTAMP_EN
   logic [31:0] ts_q;
   logic [31:0] ts_buf_q [CAP_DEPTH];

   // Free-running; only reset clears it so timestamps stay monotonic across clr_i.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) ts_q <= '0;
      else        ts_q <= ts_q + 32'd1;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < CAP_DEPTH; i++) ts_buf_q[i] <= '0;
      end else if (wr_en) begin
         ts_buf_q[wr_idx] <= ts_q;
      end
   end

   assign ts_cur = ts_q;

   for (genvar g = 0; g < 16; g++) begin : g_ts_ext
      if (g < CAP_DEPTH) begin : g_on
         assign ts_ext[g] = ts_buf_q[g];
      end else begin : g_off
         assign ts_ext[g] = '0;
      end
   end
`else
   assign ts_cur = '0;
   for (genvar g = 0; g < 16; g++) begin : g_ts_ext
      assign ts_ext[g] = '0;
   end
`endif

   logic [31:0] rd_data_d, rd_data_q;

   always_comb begin
      rd_data_d = '0;
      if (rd_sel_i == SEL_ID) begin
         rd_data_d = DBG_ID;
      end else if (rd_sel_i == SEL_STICKY) begin
         rd_data_d = 32'({rdy_stk_q, vld_stk_q});
      end else if (rd_sel_i == SEL_STATUS) begin
         rd_data_d = 32'({cap_cnt_q, state_q});
      end else if (rd_sel_i == SEL_TS) begin
         rd_data_d = ts_cur;
      end else if (rd_sel_i[7:4] == SEL_CNT_BASE[7:4]) begin
         rd_data_d = cnt_ext[rd_sel_i[3:0]];
      end else if (rd_sel_i[7:4] == SEL_BUF_BASE[7:4]) begin
         rd_data_d = buf_ext[rd_sel_i[3:0]];
      end else if (rd_sel_i[7:4] == SEL_TS_BASE[7:4]) begin
         rd_data_d = ts_ext[rd_sel_i[3:0]];
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) rd_data_q <= '0;
      else        rd_data_q <= rd_data_d;
   end

   assign rd_data_o = rd_data_q;

endmodule

// File: tb/tb_dbg_monitor.sv
// tb_dbg_monitor: scoreboard bench for dbg_monitor (NUM_CH=8, CNT_W=4, CAP_DEPTH=4).
// Stimulus pushes the value each output must hold after the next clock edge;
// a monitor pops and compares on the following falling edge.
module tb_dbg_monitor;

   localparam int NUM_CH    = 8;
   localparam int CNT_W     = 4;
   localparam int CAP_W     = 32;
   localparam int CAP_DEPTH = 4;
   localparam int ADDR_W    = 16;

   localparam int K_RD   = 0;
   localparam int K_STK  = 1;
   localparam int K_ST   = 2;
   localparam int K_TS0  = 3;
   localparam int K_TSD  = 4;

   logic              clk = 1'b0;
   logic              rst_n;
   logic              clr_i;
   logic              arm_i;
   logic [ADDR_W-1:0] trig_addr_i;
   logic [7:0]        rd_sel_i;
   logic [31:0]       rd_data_o;
   logic [2*NUM_CH-1:0] sticky_o;
   logic [1:0]        state_o;

   dbg_monitor_if #(.NUM_CH(NUM_CH), .ADDR_W(ADDR_W), .CAP_W(CAP_W)) mon_if ();

   dbg_monitor #(
      .NUM_CH(NUM_CH), .CNT_W(CNT_W), .CAP_W(CAP_W),
      .CAP_DEPTH(CAP_DEPTH), .ADDR_W(ADDR_W), .DBG_ID(32'h0022_2103)
   ) dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .clr_i       (clr_i),
      .mon         (mon_if),
      .arm_i       (arm_i),
      .trig_addr_i (trig_addr_i),
      .rd_sel_i    (rd_sel_i),
      .rd_data_o   (rd_data_o),
      .sticky_o    (sticky_o),
      .state_o     (state_o)
   );

   always #5 clk = ~clk;

   typedef struct {
      int          kind;
      string       name;
      logic [31:0] exp;
   } chk_t;

   chk_t        sb_q[$];
   int          n_req = 0;
   int          n_d   = 0;
   int          tests = 0;
   int          fails = 0;
   logic [31:0] ts0   = '0;

   task automatic expect_nx(input int kind, input string name, input logic [31:0] exp);
      chk_t c;
      c.kind = kind;
      c.name = name;
      c.exp  = exp;
      sb_q.push_back(c);
      n_req++;
   endtask

   task automatic tick();
      @(negedge clk);
      n_req = 0;
   endtask

   // ---------------- monitor ----------------
   always @(posedge clk) n_d <= n_req;

   always @(negedge clk) begin
      for (int k = 0; k < n_d; k++) begin
         if (sb_q.size() == 0) begin
            tests++;
            fails++;
            $display("FAIL sb_underflow: no expected entry for output sample");
         end else begin
            chk_t c;
            logic [31:0] act;
            c = sb_q.pop_front();
            case (c.kind)
               K_STK:   act = 32'(sticky_o);
               K_ST:    act = 32'(state_o);
               K_TSD:   act = rd_data_o - ts0;
               default: act = rd_data_o;
            endcase
            if (c.kind == K_TS0) begin
               ts0 = rd_data_o;
            end else begin
               tests++;
               if (act !== c.exp) begin
                  fails++;
                  $display("FAIL %s: got %h expected %h", c.name, act, c.exp);
               end
            end
         end
      end
   end

   initial begin
      #100000;
      $display("FAIL watchdog: simulation did not complete in time");
      $fatal(1, "watchdog");
   end

   // ---------------- stimulus ----------------
   initial begin
      rst_n               = 1'b0;
      clr_i               = 1'b0;
      arm_i               = 1'b0;
      trig_addr_i         = 16'd7;
      rd_sel_i            = 8'd0;
      mon_if.vld_i        = '0;
      mon_if.rdy_i        = '0;
      mon_if.cap_en_i     = 1'b0;
      mon_if.cap_addr_i   = '0;
      mon_if.cap_data_i   = '0;
      repeat (3) tick();
      rst_n = 1'b1;
      tick();

      // reset state
      rd_sel_i = 8'd0;
      expect_nx(K_RD,  "id",          32'h0022_2103);
      expect_nx(K_ST,  "rst_state",   32'd0);
      expect_nx(K_STK, "rst_sticky",  32'd0);
      tick();

      // sticky set / clear-wins
      mon_if.vld_i = 8'h08;
      tick();
      mon_if.vld_i = 8'h00;
      rd_sel_i = 8'd1;
      expect_nx(K_STK, "stk_vld3",    32'h0008);
      expect_nx(K_RD,  "rd_stk_vld3", 32'h0008);
      tick();
      clr_i = 1'b1; mon_if.vld_i = 8'h08;
      expect_nx(K_STK, "stk_clr_wins", 32'h0000);
      tick();
      clr_i = 1'b0; mon_if.vld_i = 8'h00;
      expect_nx(K_STK, "stk_after_clr", 32'h0000);
      tick();
      mon_if.rdy_i = 8'h04;
      tick();
      mon_if.rdy_i = 8'h00;
      expect_nx(K_STK, "stk_rdy2", 32'h0400);
      tick();
      clr_i = 1'b1;
      tick();
      clr_i = 1'b0;

      // saturating counter on ch0
      mon_if.vld_i = 8'h01; mon_if.rdy_i = 8'h01;
      repeat (5) tick();
      mon_if.vld_i = 8'h00; mon_if.rdy_i = 8'h00;
      rd_sel_i = 8'd16;
      expect_nx(K_RD, "cnt0_5", 32'd5);
      tick();
      mon_if.vld_i = 8'h01; mon_if.rdy_i = 8'h01;
      repeat (15) tick();
      mon_if.vld_i = 8'h00; mon_if.rdy_i = 8'h00;
      rd_sel_i = 8'd16;
      expect_nx(K_RD,  "cnt0_sat", 32'd15);
      expect_nx(K_STK, "stk_ch0",  32'h0101);
      tick();
      rd_sel_i = 8'd17;
      expect_nx(K_RD, "cnt1_idle", 32'd0);
      tick();
      clr_i = 1'b1; mon_if.vld_i = 8'h01; mon_if.rdy_i = 8'h01;
      tick();
      clr_i = 1'b0; mon_if.vld_i = 8'h00; mon_if.rdy_i = 8'h00;
      rd_sel_i = 8'd16;
      expect_nx(K_RD, "cnt0_clr", 32'd0);
      tick();
      rd_sel_i = 8'd24;
      expect_nx(K_RD, "cnt_oor", 32'd0);
      tick();
      rd_sel_i = 8'd4;
      expect_nx(K_RD, "sel_unmapped", 32'd0);
      tick();

      // capture window
      arm_i = 1'b1;
      tick();
      arm_i = 1'b0;
      rd_sel_i = 8'd2;
      expect_nx(K_ST, "armed",        32'd1);
      expect_nx(K_RD, "status_armed", 32'd1);
      tick();
      mon_if.cap_en_i = 1'b1; mon_if.cap_addr_i = 16'd5; mon_if.cap_data_i = 32'h99;
      expect_nx(K_ST, "no_match", 32'd1);
      tick();
      mon_if.cap_addr_i = 16'd7; mon_if.cap_data_i = 32'hA1;
      expect_nx(K_ST, "trig", 32'd2);
      tick();
      mon_if.cap_addr_i = 16'd3; mon_if.cap_data_i = 32'hB2;
      rd_sel_i = 8'd2;
      expect_nx(K_ST, "cap2",        32'd2);
      expect_nx(K_RD, "status_cap1", 32'd6);
      tick();
      mon_if.cap_data_i = 32'hC3;
      expect_nx(K_ST, "cap3", 32'd2);
      tick();
      mon_if.cap_data_i = 32'hD4;
      expect_nx(K_ST, "done", 32'd3);
      tick();
      mon_if.cap_en_i = 1'b0;
      arm_i = 1'b1;
      rd_sel_i = 8'd2;
      expect_nx(K_RD, "status_done",  32'd19);
      expect_nx(K_ST, "arm_in_done",  32'd3);
      tick();
      arm_i = 1'b0;
      mon_if.cap_en_i = 1'b1; mon_if.cap_addr_i = 16'd7; mon_if.cap_data_i = 32'hEE;
      rd_sel_i = 8'd32;
      expect_nx(K_RD, "buf0", 32'hA1);
      tick();
      mon_if.cap_en_i = 1'b0;
      rd_sel_i = 8'd33; expect_nx(K_RD, "buf1", 32'hB2); tick();
      rd_sel_i = 8'd34; expect_nx(K_RD, "buf2", 32'hC3); tick();
      rd_sel_i = 8'd35; expect_nx(K_RD, "buf3", 32'hD4); tick();
      rd_sel_i = 8'd36; expect_nx(K_RD, "buf_oor", 32'd0); tick();
      rd_sel_i = 8'd32; expect_nx(K_RD, "buf0_kept_in_done", 32'hA1); tick();
      clr_i = 1'b1;
      expect_nx(K_ST, "clr_idle", 32'd0);
      tick();
      clr_i = 1'b0;
      rd_sel_i = 8'd32; expect_nx(K_RD, "buf0_after_clr", 32'hA1); tick();
      rd_sel_i = 8'd2;  expect_nx(K_RD, "status_after_clr", 32'd0); tick();

      // reset during capture
      arm_i = 1'b1;
      tick();
      arm_i = 1'b0;
      mon_if.cap_en_i = 1'b1; mon_if.cap_addr_i = 16'd7; mon_if.cap_data_i = 32'h11;
      tick();
      mon_if.cap_data_i = 32'h22;
      tick();
      mon_if.cap_en_i = 1'b0;
      rd_sel_i = 8'd32;
      expect_nx(K_RD, "mid_buf0", 32'h11);
      expect_nx(K_ST, "mid_state", 32'd2);
      tick();
      rst_n = 1'b0;
      expect_nx(K_ST, "rst_mid_state", 32'd0);
      expect_nx(K_RD, "rst_mid_rd",    32'd0);
      tick();
      rst_n = 1'b1;
      rd_sel_i = 8'd32; expect_nx(K_RD, "rst_buf0", 32'd0); tick();
      rd_sel_i = 8'd33; expect_nx(K_RD, "rst_buf1", 32'd0); tick();

      // timestamps: two captures three cycles apart
      arm_i = 1'b1;
      tick();
      arm_i = 1'b0;
      mon_if.cap_en_i = 1'b1; mon_if.cap_addr_i = 16'd7; mon_if.cap_data_i = 32'h1;
      tick();
      mon_if.cap_en_i = 1'b0;
      repeat (2) tick();
      mon_if.cap_en_i = 1'b1; mon_if.cap_data_i = 32'h2;
      tick();
      mon_if.cap_en_i = 1'b0;
      rd_sel_i = 8'd2;
      expect_nx(K_RD, "status_ts", 32'd10);
      tick();
`ifdef DBG_MONITOR_TIMESTAMP_EN
      rd_sel_i = 8'd48; expect_nx(K_TS0, "ts0", 32'd0); tick();
      rd_sel_i = 8'd49; expect_nx(K_TSD, "ts_delta", 32'd3); tick();
`else
      rd_sel_i = 8'd48; expect_nx(K_RD, "ts_buf0_off", 32'd0); tick();
      rd_sel_i = 8'd49; expect_nx(K_RD, "ts_buf1_off", 32'd0); tick();
      rd_sel_i = 8'd3;  expect_nx(K_RD, "ts_off",      32'd0); tick();
`endif
      rd_sel_i = 8'd33; expect_nx(K_RD, "ts_cap_buf1", 32'h2); tick();

      repeat (2) tick();
      if (sb_q.size() != 0) begin
         tests++;
         fails++;
         $display("FAIL sb_leftover: got %0d entries expected 0", sb_q.size());
      end
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
